// File: rtl/nx_node_inbound_pkg.sv
// Shared node types: inbound message layout, SIGNAL command, slot encodings,
// and the buffered entry format used by inbound receivers.
package nx_node_inbound_pkg;

    localparam int unsigned RAM_ADDR_W  = 10;
    localparam int unsigned RAM_DATA_W  = 32;
    localparam int unsigned NODE_ADDR_W = 11;

    typedef enum logic [1:0] {
        NODE_COMMAND_LOAD    = 2'd0,
        NODE_COMMAND_SIGNAL  = 2'd1,
        NODE_COMMAND_CONTROL = 2'd2,
        NODE_COMMAND_TRACE   = 2'd3
    } node_command_t;

    typedef enum logic [1:0] {
        SLOT_PRESERVE = 2'd0,
        SLOT_INVERSE  = 2'd1,
        SLOT_LOWER    = 2'd2,
        SLOT_UPPER    = 2'd3
    } node_slot_t;

    typedef struct packed {
        node_command_t command;
    } node_header_t;

    typedef struct packed {
        logic [NODE_ADDR_W-1:0] address;
        node_slot_t             slot;
        logic [7:0]             data;
    } node_signal_t;

    typedef struct packed {
        node_header_t header;
        node_signal_t payload;
    } node_message_t;

    typedef struct packed {
        logic [NODE_ADDR_W-1:0] address;
        node_slot_t             slot;
        logic [7:0]             data;
    } inbound_entry_t;

    // Maps a message slot encoding onto the physical slot bit for the current core slot.
    function automatic logic resolve_slot(node_slot_t slot, logic current);
        case (slot)
            SLOT_PRESERVE: return current;
            SLOT_INVERSE:  return !current;
            SLOT_LOWER:    return 1'b0;
            default:       return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/nx_node_inbound_if.sv
// Inbound message handshake plus data RAM write port of the SIGNAL receiver.
interface nx_node_inbound_if;
    import nx_node_inbound_pkg::*;

    node_message_t             msg_data;
    logic                      msg_valid;
    logic                      msg_ready;
    logic [RAM_ADDR_W-1:0]     data_addr;
    logic [RAM_DATA_W-1:0]     data_wr_data;
    logic [RAM_DATA_W-1:0]     data_wr_strb;
    logic                      data_wr_en;

    // slave: the receiver; master: the message source and RAM it drives.
    modport slave (
        input  msg_data, msg_valid,
        output msg_ready,
        output data_addr, data_wr_data, data_wr_strb, data_wr_en
    );

    modport master (
        output msg_data, msg_valid,
        input  msg_ready,
        input  data_addr, data_wr_data, data_wr_strb, data_wr_en
    );

endinterface

// File: rtl/nx_inbound_fifo.sv
// Synchronous FIFO of inbound entries; full/empty/level come from registered occupancy.
module nx_inbound_fifo
    import nx_node_inbound_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_push,
    input  inbound_entry_t               i_data,
    input  logic                         i_pop,
    output inbound_entry_t               o_data,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    inbound_entry_t   mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    assign o_full  = (level_q == LVL_W'(DEPTH));
    assign o_empty = (level_q == '0);
    assign o_level = level_q;
    assign o_data  = mem_q[rd_ptr_q];

    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      level_d = level_q + 1'b1;
        else if (!do_push && do_pop) level_d = level_q - 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_ptr_q] <= i_data;
    end

endmodule

// File: rtl/nx_node_inbound.sv
// Node SIGNAL receiver: filters inbound messages, buffers SIGNALs and writes
// each payload byte into its resolved data RAM lane whenever the core leaves the RAM free.
module nx_node_inbound
    import nx_node_inbound_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    nx_node_inbound_if.slave        bus,
    input  logic                    i_slot,
    input  logic                    i_core_busy,
    output logic                    o_idle,
    output logic                    o_dropped
);

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);

    inbound_entry_t         push_entry, head;
    logic                   full, empty;
    logic [LVL_W-1:0]       level;
    logic                   accept, is_signal, push, pop;
    logic                   slot_bit;
    logic [1:0]             lane;

    logic [RAM_ADDR_W-1:0]  addr_q, addr_d;
    logic [RAM_DATA_W-1:0]  data_q, data_d;
    logic [RAM_DATA_W-1:0]  strb_q, strb_d;
    logic                   wr_en_q, wr_en_d;
    logic                   dropped_q, dropped_d;

    // Ready depends only on registered occupancy, so a same-cycle pop never opens a full FIFO.
    assign bus.msg_ready = !full && !i_rst;
    assign accept        = bus.msg_valid && bus.msg_ready;
    assign is_signal     = (bus.msg_data.header.command == NODE_COMMAND_SIGNAL);
    assign push          = accept && is_signal;
    assign pop           = !empty && !i_core_busy;

    assign push_entry.address = bus.msg_data.payload.address;
    assign push_entry.slot    = bus.msg_data.payload.slot;
    assign push_entry.data    = bus.msg_data.payload.data;

    nx_inbound_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push),
        .i_data  (push_entry),
        .i_pop   (pop),
        .o_data  (head),
        .o_full  (full),
        .o_empty (empty),
        .o_level (level)
    );

    assign slot_bit = resolve_slot(head.slot, i_slot);
    assign lane     = {head.address[0], slot_bit};

    always_comb begin
        addr_d    = addr_q;
        data_d    = data_q;
        strb_d    = strb_q;
        wr_en_d   = pop;
        dropped_d = accept && !is_signal;
        if (pop) begin
            addr_d = head.address[NODE_ADDR_W-1:1];
            data_d = {4{head.data}};
            strb_d = RAM_DATA_W'(8'hFF) << {lane, 3'b000};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr_q    <= '0;
            data_q    <= '0;
            strb_q    <= '0;
            wr_en_q   <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            data_q    <= data_d;
            strb_q    <= strb_d;
            wr_en_q   <= wr_en_d;
            dropped_q <= dropped_d;
        end
    end

    assign bus.data_addr    = addr_q;
    assign bus.data_wr_data = data_q;
    assign bus.data_wr_strb = strb_q;
    assign bus.data_wr_en   = wr_en_q;
    assign o_dropped        = dropped_q;
    assign o_idle           = (level == '0) && !wr_en_q;

endmodule

// File: tb/tb_nx_node_inbound.sv
// Directed bench for nx_node_inbound with a scoreboard of expected RAM writes.
module tb_nx_node_inbound;
    import nx_node_inbound_pkg::*;

    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] data;
        logic [31:0] strb;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic slot;
    logic busy;
    logic idle;
    logic dropped;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    exp_t        sb [$];
    logic [31:0] last_data;

    nx_node_inbound_if bus ();

    nx_node_inbound #(
        .FIFO_DEPTH (4)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .bus         (bus),
        .i_slot      (slot),
        .i_core_busy (busy),
        .o_idle      (idle),
        .o_dropped   (dropped)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input node_command_t c, input logic [10:0] a,
                        input node_slot_t s, input logic [7:0] d);
        node_message_t m;
        m.header.command = c;
        m.payload.address = a;
        m.payload.slot    = s;
        m.payload.data    = d;
        bus.msg_data  = m;
        bus.msg_valid = 1'b1;
    endtask

    function automatic exp_t model(input logic [10:0] a, input node_slot_t s,
                                   input logic [7:0] d, input logic cur);
        exp_t e;
        logic sbit;
        logic [1:0] ln;
        case (s)
            SLOT_PRESERVE: sbit = cur;
            SLOT_INVERSE:  sbit = ~cur;
            SLOT_LOWER:    sbit = 1'b0;
            default:       sbit = 1'b1;
        endcase
        ln = {a[0], sbit};
        e.addr = a[10:1];
        e.data = {d, d, d, d};
        e.strb = 32'h000000FF << (ln * 8);
        return e;
    endfunction

    task automatic drain(input string tag);
        int unsigned n = 0;
        while ((sb.size() != 0 || !idle) && n < 32) begin
            step();
            n++;
        end
        chk({tag, "_drained"}, sb.size(), 0);
        chk({tag, "_idle"}, idle, 1);
    endtask

    // Scoreboard: every write enable must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.data_wr_en === 1'b1) begin
            chk("wr_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("wr_addr", {22'd0, bus.data_addr}, {22'd0, e.addr});
                chk("wr_data", bus.data_wr_data, e.data);
                chk("wr_strb", bus.data_wr_strb, e.strb);
            end
            last_data = bus.data_wr_data;
        end
    end

    initial begin
        rst           = 1'b1;
        slot          = 1'b0;
        busy          = 1'b0;
        bus.msg_valid = 1'b0;
        bus.msg_data  = '0;
        last_data     = '0;

        // Reset state
        step();
        step();
        chk("rst_ready", bus.msg_ready, 0);
        chk("rst_wr_en", bus.data_wr_en, 0);
        chk("rst_addr", {22'd0, bus.data_addr}, 0);
        chk("rst_data", bus.data_wr_data, 0);
        chk("rst_strb", bus.data_wr_strb, 0);
        chk("rst_idle", idle, 1);
        chk("rst_dropped", dropped, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", bus.msg_ready, 1);

        // 1: single SIGNAL, lane 3, latency N+2
        step();
        send(NODE_COMMAND_SIGNAL, 11'h0A5, SLOT_UPPER, 8'h3C);
        sb.push_back('{addr: 10'h052, data: 32'h3C3C3C3C, strb: 32'hFF000000});
        chk("t1_ready", bus.msg_ready, 1);
        step();
        bus.msg_valid = 1'b0;
        chk("t1_n1_wr_en", bus.data_wr_en, 0);
        chk("t1_n1_idle", idle, 0);
        step();
        chk("t1_n2_wr_en", bus.data_wr_en, 1);
        step();
        chk("t1_n3_wr_en", bus.data_wr_en, 0);
        drain("t1");

        // 2: PRESERVE then INVERSE with i_slot=1, addr[0]=0
        slot = 1'b1;
        send(NODE_COMMAND_SIGNAL, 11'h1F2, SLOT_PRESERVE, 8'hA7);
        sb.push_back('{addr: 10'h0F9, data: 32'hA7A7A7A7, strb: 32'h0000FF00});
        step();
        send(NODE_COMMAND_SIGNAL, 11'h1F2, SLOT_INVERSE, 8'h5E);
        sb.push_back('{addr: 10'h0F9, data: 32'h5E5E5E5E, strb: 32'h000000FF});
        step();
        bus.msg_valid = 1'b0;
        drain("t2");

        // 3: fill with core busy, fifth message refused, then drain back-to-back
        slot = 1'b0;
        busy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            send(NODE_COMMAND_SIGNAL, 11'(k * 37 + 5), node_slot_t'(k % 4), 8'(8'h40 + k));
            chk("t3_ready", bus.msg_ready, 32'(k < 4));
            if (k < 4) sb.push_back(model(11'(k * 37 + 5), node_slot_t'(k % 4), 8'(8'h40 + k), 1'b0));
            step();
        end
        bus.msg_valid = 1'b0;
        repeat (3) step();
        chk("t3_full_ready", bus.msg_ready, 0);
        chk("t3_busy_no_wr", bus.data_wr_en, 0);
        chk("t3_full_idle", idle, 0);
        busy = 1'b0;
        step();
        chk("t3_ready_back", bus.msg_ready, 1);
        chk("t3_wr0", bus.data_wr_en, 1);
        for (int k = 1; k < 4; k++) begin
            step();
            chk("t3_wr_consec", bus.data_wr_en, 1);
        end
        step();
        chk("t3_wr_done", bus.data_wr_en, 0);
        drain("t3");

        // 4: non-SIGNAL message is accepted and dropped
        send(NODE_COMMAND_LOAD, 11'h033, SLOT_LOWER, 8'h99);
        chk("t4_ready", bus.msg_ready, 1);
        step();
        bus.msg_valid = 1'b0;
        chk("t4_dropped", dropped, 1);
        chk("t4_idle", idle, 1);
        step();
        chk("t4_dropped_pulse", dropped, 0);
        chk("t4_no_wr", bus.data_wr_en, 0);
        chk("t4_idle2", idle, 1);

        // 5: reset with three queued entries and a write pending
        busy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            send(NODE_COMMAND_SIGNAL, 11'(k * 11 + 300), SLOT_UPPER, 8'(8'hC0 + k));
            sb.push_back(model(11'(k * 11 + 300), SLOT_UPPER, 8'(8'hC0 + k), 1'b0));
            step();
        end
        bus.msg_valid = 1'b0;
        busy = 1'b0;
        step();
        chk("t5_pending", bus.data_wr_en, 1);
        rst  = 1'b1;
        busy = 1'b1;
        step();
        chk("t5_rst_wr_en", bus.data_wr_en, 0);
        chk("t5_rst_idle", idle, 1);
        chk("t5_rst_ready", bus.msg_ready, 0);
        sb.delete();
        step();
        rst  = 1'b0;
        busy = 1'b0;
        #1;
        chk("t5_ready_after", bus.msg_ready, 1);
        repeat (6) step();
        chk("t5_no_stale", bus.data_wr_en, 0);
        drain("t5");

        // 6: same row and lane, arrival order preserved
        send(NODE_COMMAND_SIGNAL, 11'h07E, SLOT_LOWER, 8'h11);
        sb.push_back(model(11'h07E, SLOT_LOWER, 8'h11, 1'b0));
        step();
        send(NODE_COMMAND_SIGNAL, 11'h07E, SLOT_LOWER, 8'h22);
        sb.push_back(model(11'h07E, SLOT_LOWER, 8'h22, 1'b0));
        step();
        bus.msg_valid = 1'b0;
        drain("t6");
        chk("t6_last_wins", last_data, 32'h22222222);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
